// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite master bridge.
// A CPU-side command (read or write) is turned into exactly one AXI4-Lite
// transaction; read data and error status come back on a registered
// response port that holds until rsp_ready.
//
// Optional feature: define AXIL_CMD_MASTER_TIMEOUT_EN to enable a watchdog
// that aborts any slave wait lasting TIMEOUT_CYCLES cycles and reports it
// as an error response. Without the macro the block waits indefinitely.
//
// Handshake rule on every channel (cmd, rsp, aw, w, b, ar, r): a transfer
// happens on a rising aclk edge where valid and ready are both high; once a
// valid is raised it stays high with a stable payload until its transfer
// (the only exception is the watchdog abort path).
//
// dbg_state exposes the FSM state encoding:
//   0 IDLE, 1 WR_REQ, 2 WR_RESP, 3 RD_REQ, 4 RD_DATA, 5 RESP.
module axil_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] AXPROT = 3'b000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  // write address channel
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  // write data channel
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  // write response channel
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  // read address channel
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  // read data channel
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  // state observation
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t state;
  logic   wd_expired;

  assign m_axil_awprot = AXPROT;
  assign m_axil_arprot = AXPROT;
  assign dbg_state     = state;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_wait;

  assign wd_wait    = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                      (state == S_RD_REQ) || (state == S_RD_DATA);
  assign wd_expired = wd_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: held at zero while idle, counts each cycle spent waiting on the slave.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_cnt <= '0;
    end else if (state == S_IDLE) begin
      wd_cnt <= '0;
    end else if (wd_wait && !wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expired         = 1'b0;
`endif

  // Main FSM: sequences one transaction and owns every registered output.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_error      <= 1'b0;
      m_axil_awaddr  <= '0;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              m_axil_awaddr  <= cmd_addr;
              m_axil_wdata   <= cmd_wdata;
              m_axil_wstrb   <= cmd_wstrb;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= S_WR_REQ;
            end else begin
              m_axil_araddr  <= cmd_addr;
              m_axil_arvalid <= 1'b1;
              state          <= S_RD_REQ;
            end
          end
        end

        S_WR_REQ: begin
          // A channel counts as done once its valid has already dropped or
          // its handshake completes this edge; AW and W finish independently.
          if ((!m_axil_awvalid || m_axil_awready) &&
              (!m_axil_wvalid  || m_axil_wready)) begin
            m_axil_awvalid <= 1'b0;
            m_axil_awaddr  <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_bready  <= 1'b1;
            state          <= S_WR_RESP;
          end else if (wd_expired) begin
            m_axil_awvalid <= 1'b0;
            m_axil_awaddr  <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            rsp_valid      <= 1'b1;
            rsp_error      <= 1'b1;
            rsp_rdata      <= '0;
            state          <= S_RESP;
          end else begin
            if (m_axil_awvalid && m_axil_awready) begin
              m_axil_awvalid <= 1'b0;
              m_axil_awaddr  <= '0;
            end
            if (m_axil_wvalid && m_axil_wready) begin
              m_axil_wvalid <= 1'b0;
              m_axil_wdata  <= '0;
              m_axil_wstrb  <= '0;
            end
          end
        end

        S_WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_error     <= (m_axil_bresp != 2'b00);
            rsp_rdata     <= '0;
            state         <= S_RESP;
          end else if (wd_expired) begin
            m_axil_bready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_error     <= 1'b1;
            rsp_rdata     <= '0;
            state         <= S_RESP;
          end
        end

        S_RD_REQ: begin
          // The R channel is deliberately ignored here: rready stays low.
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_rready  <= 1'b1;
            state          <= S_RD_DATA;
          end else if (wd_expired) begin
            m_axil_arvalid <= 1'b0;
            m_axil_araddr  <= '0;
            rsp_valid      <= 1'b1;
            rsp_error      <= 1'b1;
            rsp_rdata      <= '0;
            state          <= S_RESP;
          end
        end

        S_RD_DATA: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= m_axil_rdata;
            rsp_error     <= (m_axil_rresp != 2'b00);
            state         <= S_RESP;
          end else if (wd_expired) begin
            m_axil_rready <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_error     <= 1'b1;
            rsp_rdata     <= '0;
            state         <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: directed steps against a small AXI4-Lite
// memory slave model with adjustable ready delays and response codes.
// Expected responses are queued when a command is issued and compared when
// the response port delivers. Define AXIL_CMD_MASTER_TIMEOUT_EN for both the
// bench and the RTL to exercise the watchdog path.
module tb_axil_cmd_master;

  localparam int TO_CYC = 8;

  // clock / reset
  logic aclk;
  logic aresetn;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // DUT signals
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot, dbg_state;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  axil_cmd_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
    .AXPROT(3'b000), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .dbg_state(dbg_state)
  );

  // scoreboard and counters
  logic [32:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int n_get = 0;

  // slave model knobs and state
  logic [31:0] mem [0:15];
  int          aw_delay, w_delay;
  bit          ar_en;
  logic [1:0]  bresp_val, rresp_val;
  bit          rdata_ovr;
  logic [31:0] rdata_ovr_val;
  bit          have_aw, have_w, b_pend;
  int          aw_cnt, w_cnt;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  bit          p_aw_hs, p_w_hs, p_b_hs, p_ar_hs, p_r_hs;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  // Slave model: samples handshakes at the edge, updates its outputs 1 time unit later.
  always begin
    @(posedge aclk);
    p_aw_hs  = m_axil_awvalid && m_axil_awready;
    p_w_hs   = m_axil_wvalid && m_axil_wready;
    p_b_hs   = m_axil_bvalid && m_axil_bready;
    p_ar_hs  = m_axil_arvalid && m_axil_arready;
    p_r_hs   = m_axil_rvalid && m_axil_rready;
    p_awaddr = m_axil_awaddr;
    p_wdata  = m_axil_wdata;
    p_wstrb  = m_axil_wstrb;
    p_araddr = m_axil_araddr;
    #1;
    if (!aresetn) begin
      m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
      m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
      have_aw = 1'b0; have_w = 1'b0; b_pend = 1'b0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (p_aw_hs) begin have_aw = 1'b1; s_awaddr = p_awaddr; aw_cnt = 0; end
      if (p_w_hs) begin have_w = 1'b1; s_wdata = p_wdata; s_wstrb = p_wstrb; w_cnt = 0; end
      if (p_b_hs) m_axil_bvalid = 1'b0;
      if (p_r_hs) m_axil_rvalid = 1'b0;
      if (b_pend) begin m_axil_bvalid = 1'b1; m_axil_bresp = bresp_val; b_pend = 1'b0; end
      if (have_aw && have_w) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
        have_aw = 1'b0; have_w = 1'b0; b_pend = 1'b1;
      end
      if (p_ar_hs) begin
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = rdata_ovr ? rdata_ovr_val : mem[p_araddr[5:2]];
        m_axil_rresp  = rresp_val;
      end
      m_axil_awready = 1'b0;
      if (m_axil_awvalid && !have_aw) begin
        if (aw_cnt >= aw_delay) m_axil_awready = 1'b1;
        else aw_cnt++;
      end
      m_axil_wready = 1'b0;
      if (m_axil_wvalid && !have_w) begin
        if (w_cnt >= w_delay) m_axil_wready = 1'b1;
        else w_cnt++;
      end
      m_axil_arready = m_axil_arvalid && ar_en;
    end
  end

  // channel monitors
  int          aw_hi, w_hi, ar_hi, aw_chg, rsp_hs;
  logic [31:0] mon_addr;

  // Counts cycles each request valid is high and any awaddr change while awvalid is up.
  always @(negedge aclk) begin
    if (m_axil_awvalid) aw_hi++;
    if (m_axil_wvalid) w_hi++;
    if (m_axil_arvalid) ar_hi++;
    if (m_axil_awvalid && (m_axil_awaddr !== mon_addr)) aw_chg++;
  end

  // Counts completed response handshakes.
  always @(posedge aclk) begin
    if (rsp_valid && rsp_ready) rsp_hs++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one command at a negedge and holds it until accepted.
  task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [32:0] exp, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    exp_q.push_back(exp);
    for (int i = 0; i < 300; i++) begin
      if (cmd_ready) begin ok = 1'b1; acc = cyc; break; end
      @(negedge aclk);
    end
    check("cmd_accept", {63'd0, ok}, 64'd1);
    @(negedge aclk);
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
  endtask

  // Waits for a response, holds rsp_ready low for 'hold' cycles, then takes it.
  task automatic get_rsp(input int hold, output int rsp_cyc);
    logic [32:0] got, exp;
    bit seen;
    n_get++;
    rsp_ready = 1'b0;
    rsp_cyc   = -1;
    seen      = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      @(negedge aclk);
    end
    check("rsp_arrive", {63'd0, seen}, 64'd1);
    if (seen) begin
      rsp_cyc = cyc;
      got = {rsp_error, rsp_rdata};
      for (int k = 0; k < hold; k++) begin
        @(negedge aclk);
        check("rsp_hold", {30'd0, rsp_valid, rsp_error, rsp_rdata}, {30'd0, 1'b1, got});
        check("cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
      end
      rsp_ready = 1'b1;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'd0, got}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp = exp_q.pop_front();
        check("rsp_data", {31'd0, got}, {31'd0, exp});
      end
      @(negedge aclk);
      rsp_ready = 1'b0;
      check("rsp_drop", {63'd0, rsp_valid}, 64'd0);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int acc, rc, stuck;
    aresetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = 2'b00;
    aw_delay = 0; w_delay = 0; ar_en = 1'b1; bresp_val = 2'b00; rresp_val = 2'b00;
    rdata_ovr = 1'b0; rdata_ovr_val = '0;
    aw_hi = 0; w_hi = 0; ar_hi = 0; aw_chg = 0; rsp_hs = 0; mon_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'hFFFF_FFFF;

    // reset state
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
    check("rst_valids", {60'd0, m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, 1'b0}, 64'd0);
    check("rst_readies", {62'd0, m_axil_bready, m_axil_rready}, 64'd0);
    check("rst_addr", {m_axil_awaddr, m_axil_araddr}, 64'd0);
    check("rst_wdata", {28'd0, m_axil_wstrb, m_axil_wdata}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // read from preloaded memory, latency N+3
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, {1'b0, 32'hDEAD_BEEF}, acc);
    get_rsp(0, rc);
    check("rd_latency", 64'(rc - acc), 64'd3);

    // partial-strobe write, latency N+4, then read back
    do_cmd(1'b1, 32'h20, 32'h1122_3344, 4'b0101, {1'b0, 32'h0}, acc);
    get_rsp(0, rc);
    check("wr_latency", 64'(rc - acc), 64'd4);
    do_cmd(1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'hFF22_FF44}, acc);
    get_rsp(0, rc);

    // awready delayed 3 cycles, wready immediate
    aw_delay = 3;
    mon_addr = 32'h24;
    @(negedge aclk);
    aw_hi = 0; w_hi = 0; aw_chg = 0;
    do_cmd(1'b1, 32'h24, 32'hA5A5_A5A5, 4'hF, {1'b0, 32'h0}, acc);
    get_rsp(0, rc);
    check("aw_hold_cycles", 64'(aw_hi), 64'd4);
    check("w_hold_cycles", 64'(w_hi), 64'd1);
    check("awaddr_stable", 64'(aw_chg), 64'd0);
    aw_delay = 0;
    repeat (3) @(negedge aclk);
    check("no_extra_rsp", {63'd0, rsp_valid}, 64'd0);
    do_cmd(1'b0, 32'h24, 32'h0, 4'h0, {1'b0, 32'hA5A5_A5A5}, acc);
    get_rsp(0, rc);

    // error responses
    rdata_ovr = 1'b1; rdata_ovr_val = 32'h55; rresp_val = 2'b10;
    do_cmd(1'b0, 32'h0, 32'h0, 4'h0, {1'b1, 32'h55}, acc);
    get_rsp(0, rc);
    rdata_ovr = 1'b0; rresp_val = 2'b01;
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, {1'b1, 32'hDEAD_BEEF}, acc);
    get_rsp(0, rc);
    rresp_val = 2'b00; bresp_val = 2'b11;
    do_cmd(1'b1, 32'h28, 32'h1234_5678, 4'hF, {1'b1, 32'h0}, acc);
    get_rsp(0, rc);
    bresp_val = 2'b01;
    do_cmd(1'b1, 32'h2C, 32'h1234_5678, 4'hF, {1'b1, 32'h0}, acc);
    get_rsp(0, rc);
    bresp_val = 2'b00;

    // rsp_ready held low 5 cycles with the next command already waiting
    do_cmd(1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'hFF22_FF44}, acc);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    get_rsp(5, rc);
    check("ready_after_rsp", {63'd0, cmd_ready}, 64'd1);
    @(negedge aclk);
    check("accepted_next", {63'd0, cmd_ready}, 64'd0);
    check("state_after_accept", {61'd0, dbg_state}, 64'd3);
    cmd_valid = 1'b0; cmd_addr = '0;
    get_rsp(0, rc);

    // slave never raises arready
    ar_en = 1'b0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    @(negedge aclk);
    ar_hi = 0;
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, {1'b1, 32'h0}, acc);
    get_rsp(0, rc);
    check("timeout_ar_cycles", 64'(ar_hi), 64'(TO_CYC));
    check("timeout_arvalid_low", {63'd0, m_axil_arvalid}, 64'd0);
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, {1'b1, 32'h0}, acc);
    repeat (2) @(negedge aclk);
`else
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, {1'b1, 32'h0}, acc);
    stuck = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_axil_arvalid && (dbg_state == 3'd3) && !rsp_valid) stuck++;
      @(negedge aclk);
    end
    check("no_timeout_stuck", 64'(stuck), 64'd100);
`endif

    // reset in the middle of a transaction
    aresetn = 1'b0;
    #1;
    check("midrst_arvalid", {63'd0, m_axil_arvalid}, 64'd0);
    check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("midrst_state", {61'd0, dbg_state}, 64'd0);
    check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    exp_q.delete();
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    ar_en = 1'b1;
    repeat (2) @(negedge aclk);

    // recovery after reset
    do_cmd(1'b0, 32'h20, 32'h0, 4'h0, {1'b0, 32'hFF22_FF44}, acc);
    get_rsp(0, rc);
    check("post_rst_latency", 64'(rc - acc), 64'd3);
    check("rsp_count", 64'(rsp_hs), 64'(n_get));
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
